load_store_unit: RTL

Sits directly upstream of the main memory, between the execute stage and the word-wide memory port. Accepts one load/store request per transaction with byte, halfword or word size. Sign- or zero-extends load data. Turns sub-word stores into a read-modify-write, because the memory always writes four consecutive bytes.

---
 rtl/load_store_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-wide memory port.
// Sub-word stores become read-modify-write; loads are sign/zero-extended.
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_write_i,
    input  logic [1:0]               req_size_i,
    input  logic                     req_unsigned_i,
    input  logic [ADDRESS_WIDTH-1:0] req_address_i,
    input  logic [DATA_WIDTH-1:0]    req_write_data_i,
    output logic                     resp_valid_o,
    output logic [DATA_WIDTH-1:0]    resp_read_data_o,
    output logic                     resp_error_o,
    output logic [ADDRESS_WIDTH-1:0] mem_address_o,
    output logic                     mem_write_enable_o,
    output logic [DATA_WIDTH-1:0]    mem_write_value_o,
    input  logic [DATA_WIDTH-1:0]    mem_read_value_i,
    output logic [1:0]               debug_state_o
);

    // Handshake: a request is taken on a rising edge where req_valid_i and
    // req_ready_o are both high; req_ready_o is high only in IDLE, and every
    // request field is sampled on that same edge.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic                     write_q;
    logic [1:0]               size_q;
    logic                     unsigned_q;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [DATA_WIDTH-1:0]    store_data_q;
    logic [DATA_WIDTH-1:0]    word_q;
    logic [DATA_WIDTH-1:0]    result_q;
    logic                     error_q;
    logic                     write_enable_q;
    logic [DATA_WIDTH-1:0]    load_value;
    logic [DATA_WIDTH-1:0]    merged_value;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_size_i == 2'b11) begin
                        next_state = RESP;
                    end else if (!req_write_i) begin
                        next_state = READ;
                    end else if (req_size_i == 2'b10) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ:    next_state = write_q ? WRITE : RESP;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Extension for loads and lane merge for sub-word stores, both from the
    // word the memory returns for the latched address.
    always_comb begin
        load_value   = mem_read_value_i;
        merged_value = mem_read_value_i;
        case (size_q)
            2'b00: begin
                load_value   = unsigned_q
                    ? {{(DATA_WIDTH-8){1'b0}}, mem_read_value_i[7:0]}
                    : {{(DATA_WIDTH-8){mem_read_value_i[7]}}, mem_read_value_i[7:0]};
                merged_value = {mem_read_value_i[DATA_WIDTH-1:8], store_data_q[7:0]};
            end
            2'b01: begin
                load_value   = unsigned_q
                    ? {{(DATA_WIDTH-16){1'b0}}, mem_read_value_i[15:0]}
                    : {{(DATA_WIDTH-16){mem_read_value_i[15]}}, mem_read_value_i[15:0]};
                merged_value = {mem_read_value_i[DATA_WIDTH-1:16], store_data_q[15:0]};
            end
            default: begin
                load_value   = mem_read_value_i;
                merged_value = mem_read_value_i;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            write_q        <= 1'b0;
            size_q         <= 2'b00;
            unsigned_q     <= 1'b0;
            address_q      <= '0;
            store_data_q   <= '0;
            word_q         <= '0;
            result_q       <= '0;
            error_q        <= 1'b0;
            write_enable_q <= 1'b0;
        end else begin
            state          <= next_state;
            // Registered strobe: the memory is edge-sensitive to it.
            write_enable_q <= (next_state == WRITE);
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        write_q      <= req_write_i;
                        size_q       <= req_size_i;
                        unsigned_q   <= req_unsigned_i;
                        address_q    <= req_address_i;
                        store_data_q <= req_write_data_i;
                        word_q       <= req_write_data_i;
                        result_q     <= '0;
                        error_q      <= (req_size_i == 2'b11);
                    end
                end
                READ: begin
                    if (write_q) begin
                        word_q <= merged_value;
                    end else begin
                        result_q <= load_value;
                    end
                end
                RESP: begin
                    result_q <= '0;
                    error_q  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready_o        = (state == IDLE);
    assign resp_valid_o       = (state == RESP);
    assign resp_read_data_o   = (state == RESP) ? result_q : '0;
    assign resp_error_o       = (state == RESP) ? error_q : 1'b0;
    assign mem_address_o      = ((state == READ) || (state == WRITE)) ? address_q : '0;
    assign mem_write_value_o  = (state == WRITE) ? word_q : '0;
    assign mem_write_enable_o = write_enable_q;
    assign debug_state_o      = state;

endmodule
